// File: rtl/seg7_pkg.sv
// ============================================================================
// Module  : seg7_pkg
// Brief   : Shared constants for the seven-segment scan controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package seg7_pkg;

    localparam int NIBBLE_W = 4;
    localparam int SEG_W    = 7;

    typedef logic [SEG_W-1:0]    seg_t;
    typedef logic [NIBBLE_W-1:0] nibble_t;

    // Segment order gfedcba, active-low.
    localparam seg_t SEG_BLANK = 7'h7F;

    // Entry n holds the segment pattern for hex digit n.
    localparam logic [15:0][SEG_W-1:0] HEX_SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,     // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,     // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,     // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40      // 3 2 1 0
    };

endpackage

`default_nettype wire

// File: rtl/seg7_hex_decode.sv
// ============================================================================
// Module  : seg7_hex_decode
// Brief   : Combinational hex nibble to active-low segment decode with blank.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble,
    input  logic                blank,
    output logic [SEG_W-1:0]    segs
);

    always_comb begin
        segs = SEG_BLANK;
        if (!blank) begin
            segs = HEX_SEG_TABLE[nibble];
        end
    end

endmodule

`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
// ============================================================================
// Module  : seg7_scan_ctrl
// Brief   : Multiplexed seven-segment scan controller with PWM brightness and
//           frame-synchronous update. Define SEG7_LZ_BLANK_EN to blank
//           leading zero digits.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS      = 4,
    parameter int TICKS_PER_DIGIT = 200000
) (
    input  logic                         clock,
    input  logic                         clear_n,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]        dp,
    input  logic [3:0]                   bright,
    input  logic                         load,
    output logic                         pending,
    output logic                         frame_done,
    output logic [NUM_DIGITS-1:0]        enable,
    output logic [SEG_W-1:0]             segs,
    output logic                         decimal
);

    localparam int TICK_W  = $clog2(TICKS_PER_DIGIT);
    localparam int SUB_LEN = TICKS_PER_DIGIT / 16;
    localparam int SUB_W   = $clog2(SUB_LEN);
    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int DATA_W  = NIBBLE_W * NUM_DIGITS;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_DIGIT - 1);
    localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(SUB_LEN - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [TICK_W-1:0]     r_tick;
    logic [SUB_W-1:0]      r_sub_cnt;
    logic [3:0]            r_sub_idx;
    logic [IDX_W-1:0]      r_idx;

    logic [DATA_W-1:0]     r_data_act;
    logic [NUM_DIGITS-1:0] r_dp_act;
    logic [3:0]            r_bright_act;
    logic [DATA_W-1:0]     r_data_pend;
    logic [NUM_DIGITS-1:0] r_dp_pend;
    logic [3:0]            r_bright_pend;
    logic                  r_pending;

    logic                  w_tick_last;
    logic                  w_boundary;
    logic                  w_lit;
    logic [NIBBLE_W-1:0]   w_nibble;
    logic                  w_dp_sel;
    logic                  w_blank_sel;
    logic [NUM_DIGITS-1:0] w_blank_mask;
    logic [NUM_DIGITS-1:0] w_enable_nxt;
    logic [SEG_W-1:0]      w_segs_nxt;
    logic                  w_decimal_nxt;

    assign w_tick_last = (r_tick == TICK_LAST);
    assign w_boundary  = w_tick_last && (r_idx == IDX_LAST);

    // The sub-period counter runs beside the tick counter so no divider is
    // needed; a slot is exactly 16 sub-periods, so both wrap together.
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            r_tick    <= '0;
            r_sub_cnt <= '0;
            r_sub_idx <= '0;
            r_idx     <= '0;
        end else if (w_tick_last) begin
            r_tick    <= '0;
            r_sub_cnt <= '0;
            r_sub_idx <= '0;
            r_idx     <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_tick <= r_tick + 1'b1;
            if (r_sub_cnt == SUB_LAST) begin
                r_sub_cnt <= '0;
                r_sub_idx <= r_sub_idx + 1'b1;
            end else begin
                r_sub_cnt <= r_sub_cnt + 1'b1;
            end
        end
    end

    // New values only reach the display at a frame boundary so a frame never
    // shows a mix of old and new digits.
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            r_data_act    <= '0;
            r_dp_act      <= '0;
            r_bright_act  <= '0;
            r_data_pend   <= '0;
            r_dp_pend     <= '0;
            r_bright_pend <= '0;
            r_pending     <= 1'b0;
        end else if (w_boundary) begin
            r_pending <= 1'b0;
            if (load) begin
                r_data_act   <= data;
                r_dp_act     <= dp;
                r_bright_act <= bright;
            end else if (r_pending) begin
                r_data_act   <= r_data_pend;
                r_dp_act     <= r_dp_pend;
                r_bright_act <= r_bright_pend;
            end
        end else if (load) begin
            r_data_pend   <= data;
            r_dp_pend     <= dp;
            r_bright_pend <= bright;
            r_pending     <= 1'b1;
        end
    end

`ifdef SEG7_LZ_BLANK_EN
    logic w_zero_run;

    always_comb begin
        w_zero_run   = 1'b1;
        w_blank_mask = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            w_zero_run      = w_zero_run && (r_data_act[i*NIBBLE_W +: NIBBLE_W] == '0);
            w_blank_mask[i] = w_zero_run;
        end
    end
`else
    assign w_blank_mask = '0;
`endif

    assign w_lit = (r_sub_idx <= r_bright_act);

    always_comb begin
        w_enable_nxt = '1;
        w_nibble     = '0;
        w_dp_sel     = 1'b0;
        w_blank_sel  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nibble        = r_data_act[i*NIBBLE_W +: NIBBLE_W];
                w_dp_sel        = r_dp_act[i];
                w_blank_sel     = w_blank_mask[i];
                w_enable_nxt[i] = ~w_lit;
            end
        end
    end

    seg7_hex_decode u_hex_decode (
        .nibble (w_nibble),
        .blank  (w_blank_sel || !w_lit),
        .segs   (w_segs_nxt)
    );

    assign w_decimal_nxt = w_lit ? ~w_dp_sel : 1'b1;

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            frame_done <= 1'b0;
            enable     <= '1;
            segs       <= SEG_BLANK;
            decimal    <= 1'b1;
        end else begin
            frame_done <= w_boundary;
            enable     <= w_enable_nxt;
            segs       <= w_segs_nxt;
            decimal    <= w_decimal_nxt;
        end
    end

    assign pending = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
// ============================================================================
// Module  : tb_seg7_scan_ctrl
// Brief   : Self-checking bench for seg7_scan_ctrl (4 digits, 32 ticks/slot).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seg7_scan_ctrl;

    localparam int N     = 4;
    localparam int T     = 32;
    localparam int SUB   = T / 16;
    localparam int FRAME = N * T;

    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic           clock   = 1'b0;
    logic           clear_n = 1'b0;
    logic [4*N-1:0] data    = '0;
    logic [N-1:0]   dp      = '0;
    logic [3:0]     bright  = '0;
    logic           load    = 1'b0;
    logic           pending;
    logic           frame_done;
    logic [N-1:0]   enable;
    logic [6:0]     segs;
    logic           decimal;

    int n_checks = 0;
    int n_fail   = 0;
    int pos      = 0;

    // What the display is currently showing.
    logic [15:0] sh_d  = '0;
    logic [3:0]  sh_dp = '0;
    logic [3:0]  sh_br = '0;

    logic [12:0] sbq [$];

    seg7_scan_ctrl #(
        .NUM_DIGITS      (N),
        .TICKS_PER_DIGIT (T)
    ) dut (
        .clock      (clock),
        .clear_n    (clear_n),
        .data       (data),
        .dp         (dp),
        .bright     (bright),
        .load       (load),
        .pending    (pending),
        .frame_done (frame_done),
        .enable     (enable),
        .segs       (segs),
        .decimal    (decimal)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, n_fail=%0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    // Expected {enable, segs, decimal, frame_done} for the frame position p.
    function automatic logic [12:0] model(int p, logic [15:0] d, logic [3:0] dpv, logic [3:0] br);
        int          ix;
        int          tk;
        logic        lit;
        logic        bl;
        logic [15:0] sh;
        logic [3:0]  en;
        logic [6:0]  sg;
        logic        dec;
        ix  = p / T;
        tk  = p % T;
        lit = (tk / SUB) <= int'(br);
        sh  = d >> (4 * ix);
        bl  = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
        bl  = (ix > 0) && (sh == 16'h0);
`endif
        en  = 4'hF;
        sg  = 7'h7F;
        dec = 1'b1;
        if (lit) begin
            en[ix] = 1'b0;
            sg     = bl ? 7'h7F : HEX[sh[3:0]];
            dec    = ~dpv[ix];
        end
        return {en, sg, dec, (p == FRAME - 1)};
    endfunction

    task automatic advance();
        @(posedge clock);
        #1;
        pos = (pos + 1) % FRAME;
    endtask

    task automatic test_reset();
        logic [12:0] e;
        int          op;
        logic [3:0]  seq [4];
        seq     = '{4'hE, 4'hD, 4'hB, 4'h7};
        clear_n = 1'b0;
        load    = 1'b1;
        data    = 16'hFFFF;
        dp      = '1;
        bright  = '1;
        repeat (5) advance();
        n_checks++;
        if ({enable, segs, decimal, frame_done, pending} !== {4'hF, 7'h7F, 3'b100}) begin
            n_fail++;
            $display("FAIL reset_state: got en=%h segs=%h dec=%b fd=%b pend=%b, need en=F segs=7F dec=1 fd=0 pend=0",
                     enable, segs, decimal, frame_done, pending);
        end
        clear_n = 1'b1;
        load    = 1'b0;
        data    = '0;
        dp      = '0;
        bright  = '0;
        pos     = 0;
        sh_d    = '0;
        sh_dp   = '0;
        sh_br   = '0;
        for (int c = 0; c < FRAME; c++) begin
            op = pos;
            sbq.push_back(model(op, sh_d, sh_dp, sh_br));
            advance();
            e = sbq.pop_front();
            n_checks++;
            if ({enable, segs, decimal, frame_done} !== e) begin
                n_fail++;
                $display("FAIL reset_scan pos=%0d: got %h, need %h", op, {enable, segs, decimal, frame_done}, e);
            end
            if (op % T == 0) begin
                n_checks++;
                if (enable !== seq[op / T]) begin
                    n_fail++;
                    $display("FAIL reset_enable_seq pos=%0d: got %h, need %h", op, enable, seq[op / T]);
                end
            end
            n_checks++;
            if (pending !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_pending pos=%0d: got %b, need 0", op, pending);
            end
        end
    endtask

    task automatic test_load_midframe();
        logic [12:0] e;
        int          op;
        logic        pend_exp;
        logic [6:0]  dig [4];
        dig      = '{7'h19, 7'h30, 7'h24, 7'h79};
        pend_exp = 1'b0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            op = pos;
            if (c == 40) begin
                load = 1'b1; data = 16'h1234; dp = 4'h0; bright = 4'hF;
            end
            sbq.push_back(model(op, sh_d, sh_dp, sh_br));
            advance();
            load = 1'b0;
            if (c == 40) pend_exp = 1'b1;
            if (op == FRAME - 1 && pend_exp) begin
                pend_exp = 1'b0; sh_d = 16'h1234; sh_dp = 4'h0; sh_br = 4'hF;
            end
            e = sbq.pop_front();
            n_checks++;
            if ({enable, segs, decimal, frame_done} !== e) begin
                n_fail++;
                $display("FAIL midload_scan pos=%0d: got %h, need %h", op, {enable, segs, decimal, frame_done}, e);
            end
            n_checks++;
            if (pending !== pend_exp) begin
                n_fail++;
                $display("FAIL midload_pending pos=%0d: got %b, need %b", op, pending, pend_exp);
            end
            if (c >= FRAME && op % T == 0) begin
                n_checks++;
                if (segs !== dig[op / T]) begin
                    n_fail++;
                    $display("FAIL midload_digit%0d: got %h, need %h", op / T, segs, dig[op / T]);
                end
            end
        end
    endtask

    task automatic test_boundary_load();
        logic [12:0] e;
        int          op;
        for (int c = 0; c < 2 * FRAME; c++) begin
            op = pos;
            if (c == FRAME - 1) begin
                load = 1'b1; data = 16'hABCD; dp = 4'b0101; bright = 4'h9;
            end
            sbq.push_back(model(op, sh_d, sh_dp, sh_br));
            advance();
            load = 1'b0;
            if (c == FRAME - 1) begin
                sh_d = 16'hABCD; sh_dp = 4'b0101; sh_br = 4'h9;
            end
            e = sbq.pop_front();
            n_checks++;
            if ({enable, segs, decimal, frame_done} !== e) begin
                n_fail++;
                $display("FAIL bndload_scan pos=%0d: got %h, need %h", op, {enable, segs, decimal, frame_done}, e);
            end
            n_checks++;
            if (pending !== 1'b0) begin
                n_fail++;
                $display("FAIL bndload_pending pos=%0d: got %b, need 0", op, pending);
            end
            if (c == FRAME) begin
                n_checks++;
                if ({segs, decimal} !== {7'h21, 1'b0}) begin
                    n_fail++;
                    $display("FAIL bndload_digit0: got segs=%h dec=%b, need segs=21 dec=0", segs, decimal);
                end
            end
        end
    endtask

    task automatic test_bright();
        logic [12:0] e;
        int          op;
        int          cnt;
        int          need;
        logic        pend_exp;
        logic [3:0]  nbr;
        pend_exp = 1'b0;
        nbr      = 4'h0;
        cnt      = 0;
        for (int c = 0; c < 4 * FRAME; c++) begin
            op = pos;
            if (c == 5 || c == 2 * FRAME + 5) begin
                nbr  = (c == 5) ? 4'h3 : 4'hF;
                load = 1'b1; data = sh_d; dp = sh_dp; bright = nbr;
            end
            sbq.push_back(model(op, sh_d, sh_dp, sh_br));
            advance();
            load = 1'b0;
            if (c == 5 || c == 2 * FRAME + 5) pend_exp = 1'b1;
            if (op == FRAME - 1 && pend_exp) begin
                pend_exp = 1'b0; sh_br = nbr;
            end
            e = sbq.pop_front();
            n_checks++;
            if ({enable, segs, decimal, frame_done} !== e) begin
                n_fail++;
                $display("FAIL bright_scan pos=%0d: got %h, need %h", op, {enable, segs, decimal, frame_done}, e);
            end
            if ((c >= FRAME && c < 2 * FRAME) || c >= 3 * FRAME) begin
                need = (c < 2 * FRAME) ? 8 : 32;
                if (enable[op / T] === 1'b0) cnt++;
                if (op % T == T - 1) begin
                    n_checks++;
                    if (cnt != need) begin
                        n_fail++;
                        $display("FAIL bright_duty slot%0d: got %0d low cycles, need %0d", op / T, cnt, need);
                    end
                    cnt = 0;
                end
            end
            if (c >= 3 * FRAME) begin
                n_checks++;
                if ($countones(~enable) != 1) begin
                    n_fail++;
                    $display("FAIL bright_full_onehot pos=%0d: got enable=%h, need one low bit", op, enable);
                end
            end
        end
    endtask

    task automatic test_overwrite();
        logic [12:0] e;
        int          op;
        logic        pend_exp;
        pend_exp = 1'b0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            op = pos;
            if (c == 10) begin
                load = 1'b1; data = 16'h5555; dp = 4'hF; bright = 4'h2;
            end
            if (c == 50) begin
                load = 1'b1; data = 16'h9876; dp = 4'h0; bright = 4'hF;
            end
            sbq.push_back(model(op, sh_d, sh_dp, sh_br));
            advance();
            load = 1'b0;
            if (c == 10) pend_exp = 1'b1;
            if (op == FRAME - 1 && pend_exp) begin
                pend_exp = 1'b0; sh_d = 16'h9876; sh_dp = 4'h0; sh_br = 4'hF;
            end
            e = sbq.pop_front();
            n_checks++;
            if ({enable, segs, decimal, frame_done} !== e) begin
                n_fail++;
                $display("FAIL overwrite_scan pos=%0d: got %h, need %h", op, {enable, segs, decimal, frame_done}, e);
            end
            n_checks++;
            if (pending !== pend_exp) begin
                n_fail++;
                $display("FAIL overwrite_pending pos=%0d: got %b, need %b", op, pending, pend_exp);
            end
        end
    endtask

    task automatic test_lz();
        logic [12:0] e;
        int          op;
        logic        pend_exp;
        logic [6:0]  lead;
        logic [6:0]  dig [4];
`ifdef SEG7_LZ_BLANK_EN
        lead = 7'h7F;
`else
        lead = 7'h40;
`endif
        dig      = '{7'h40, 7'h78, lead, lead};
        pend_exp = 1'b0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            op = pos;
            if (c == 20) begin
                load = 1'b1; data = 16'h0070; dp = 4'b0001; bright = 4'hF;
            end
            sbq.push_back(model(op, sh_d, sh_dp, sh_br));
            advance();
            load = 1'b0;
            if (c == 20) pend_exp = 1'b1;
            if (op == FRAME - 1 && pend_exp) begin
                pend_exp = 1'b0; sh_d = 16'h0070; sh_dp = 4'b0001; sh_br = 4'hF;
            end
            e = sbq.pop_front();
            n_checks++;
            if ({enable, segs, decimal, frame_done} !== e) begin
                n_fail++;
                $display("FAIL lz_scan pos=%0d: got %h, need %h", op, {enable, segs, decimal, frame_done}, e);
            end
            if (c >= FRAME && op % T == T / 2) begin
                n_checks++;
                if ({segs, decimal} !== {dig[op / T], (op / T) != 0}) begin
                    n_fail++;
                    $display("FAIL lz_digit%0d: got segs=%h dec=%b, need segs=%h dec=%b",
                             op / T, segs, decimal, dig[op / T], (op / T) != 0);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [12:0] e;
        int          op;
        for (int c = 0; c < 2 * T + 5; c++) begin
            op = pos;
            if (c == 10) begin
                load = 1'b1; data = 16'h1111; dp = 4'hF; bright = 4'h1;
            end
            sbq.push_back(model(op, sh_d, sh_dp, sh_br));
            advance();
            load = 1'b0;
            e = sbq.pop_front();
            n_checks++;
            if ({enable, segs, decimal, frame_done} !== e) begin
                n_fail++;
                $display("FAIL rstmid_pre pos=%0d: got %h, need %h", op, {enable, segs, decimal, frame_done}, e);
            end
        end
        clear_n = 1'b0;
        advance();
        n_checks++;
        if ({enable, segs, decimal, frame_done, pending} !== {4'hF, 7'h7F, 3'b100}) begin
            n_fail++;
            $display("FAIL rstmid_state: got en=%h segs=%h dec=%b fd=%b pend=%b, need en=F segs=7F dec=1 fd=0 pend=0",
                     enable, segs, decimal, frame_done, pending);
        end
        clear_n = 1'b1;
        pos     = 0;
        sh_d    = '0;
        sh_dp   = '0;
        sh_br   = '0;
        for (int c = 0; c < FRAME; c++) begin
            op = pos;
            sbq.push_back(model(op, sh_d, sh_dp, sh_br));
            advance();
            e = sbq.pop_front();
            n_checks++;
            if ({enable, segs, decimal, frame_done} !== e) begin
                n_fail++;
                $display("FAIL rstmid_scan pos=%0d: got %h, need %h", op, {enable, segs, decimal, frame_done}, e);
            end
            n_checks++;
            if (pending !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_pending pos=%0d: got %b, need 0", op, pending);
            end
            if (c == 0) begin
                n_checks++;
                if (enable !== 4'hE) begin
                    n_fail++;
                    $display("FAIL rstmid_restart: got enable=%h, need E", enable);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_midframe();
        test_boundary_load();
        test_bright();
        test_overwrite();
        test_lz();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
